// File: rtl/memory_access_stage.sv
// memory_access_stage: data memory / stack access with stack pointer and MEM/WB pipeline latch
module memory_access_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11,
  parameter logic [ADDR_W-1:0] SP_RESET = '1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              push_in,
  input  logic              pop_in,
  input  logic              wb_en_in,
  input  logic [2:0]        dest_reg_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              wb_en_out,
  output logic              mem_to_reg_out,
  output logic [2:0]        dest_reg_out,
  output logic [DATA_W-1:0] mem_data_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [ADDR_W-1:0] sp_out,
  output logic              stack_ovf,
  output logic              stack_udf,
  output logic              op_err
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] addr, sp_inc, sp_dec, wa, ra;
  logic [DATA_W-1:0] wd;
  logic multi, go, do_rd, do_wr, do_push, do_pop, we;
  always_comb begin
    addr    = alu_result_in[ADDR_W-1:0];
    sp_inc  = sp_out + 1'b1;
    sp_dec  = sp_out - 1'b1;
    multi   = (mem_read_in & mem_write_in) | (mem_read_in & push_in) | (mem_read_in & pop_in)
            | (mem_write_in & push_in) | (mem_write_in & pop_in) | (push_in & pop_in);
    go      = !stall && !flush;
    do_rd   = go && !multi && mem_read_in;
    do_wr   = go && !multi && mem_write_in;
    do_push = go && !multi && push_in;
    do_pop  = go && !multi && pop_in;
    // debug preload shares the single write port, only while the pipeline is frozen
    we      = !reset && (do_wr || do_push || (stall && !flush && dbg_we));
    wa      = do_wr ? addr : do_push ? sp_out : dbg_addr;
    wd      = (do_wr || do_push) ? store_data_in : dbg_wdata;
    ra      = do_pop ? sp_inc : addr;
  end
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_en_out      <= 1'b0;
      mem_to_reg_out <= 1'b0;
      dest_reg_out   <= '0;
      mem_data_out   <= '0;
      alu_result_out <= '0;
      sp_out         <= SP_RESET;
      stack_ovf      <= 1'b0;
      stack_udf      <= 1'b0;
      op_err         <= 1'b0;
    end else if (!stall || flush) begin
      wb_en_out      <= go && !multi && wb_en_in;
      mem_to_reg_out <= do_rd || do_pop;
      dest_reg_out   <= dest_reg_in;
      alu_result_out <= alu_result_in;
      if (do_rd || do_pop) mem_data_out <= mem[ra];
      sp_out         <= do_push ? sp_dec : do_pop ? sp_inc : sp_out;
      stack_ovf      <= stack_ovf | (do_push && sp_out == '0);
      stack_udf      <= stack_udf | (do_pop && sp_out == '1);
      op_err         <= op_err | (go && multi);
    end
  end
endmodule

// File: tb/tb_memory_access_stage.sv
// tb_memory_access_stage: directed and random checks of memory_access_stage against a behavioural model
module tb_memory_access_stage;
  logic clk = 1'b0;
  logic reset, stall, flush, rd, wr, pu, po, wb, dbg_we;
  logic [2:0] dest;
  logic [15:0] alu, sd, dbg_wdata;
  logic [10:0] dbg_addr;
  logic wb_en_out, mem_to_reg_out, stack_ovf, stack_udf, op_err;
  logic [2:0] dest_reg_out;
  logic [15:0] mem_data_out, alu_result_out;
  logic [10:0] sp_out;
  int checks = 0, errors = 0;
  logic [15:0] mm [2048];
  bit known [2048];
  logic e_wb, e_m2r, e_ovf, e_udf, e_err, dk;
  logic [2:0] e_dest;
  logic [15:0] e_data, e_alu;
  int e_sp;

  memory_access_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .mem_read_in(rd), .mem_write_in(wr), .push_in(pu), .pop_in(po),
    .wb_en_in(wb), .dest_reg_in(dest), .alu_result_in(alu), .store_data_in(sd),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .wb_en_out(wb_en_out), .mem_to_reg_out(mem_to_reg_out), .dest_reg_out(dest_reg_out),
    .mem_data_out(mem_data_out), .alu_result_out(alu_result_out), .sp_out(sp_out),
    .stack_ovf(stack_ovf), .stack_udf(stack_udf), .op_err(op_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    reset = 0; stall = 0; flush = 0; rd = 0; wr = 0; pu = 0; po = 0;
    wb = 0; dest = 0; alu = 0; sd = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
  endtask

  task automatic op(input bit r, input bit w, input bit p, input bit q,
                    input logic [15:0] a, input logic [15:0] d);
    idle();
    rd = r; wr = w; pu = p; po = q; alu = a; sd = d;
    wb = 1'($urandom); dest = 3'($urandom);
  endtask

  // advance one clock, update the reference model from the spec rules, compare all outputs
  task automatic step();
    int n, a;
    @(posedge clk);
    #1;
    n = int'(rd) + int'(wr) + int'(pu) + int'(po);
    a = int'(alu) % 2048;
    if (reset) begin
      e_wb = 0; e_m2r = 0; e_dest = 0; e_data = 0; dk = 1; e_alu = 0;
      e_sp = 2047; e_ovf = 0; e_udf = 0; e_err = 0;
    end else if (flush || !stall) begin
      e_dest = dest; e_alu = alu; e_wb = 0; e_m2r = 0;
      if (!flush && n > 1) e_err = 1;
      else if (!flush) begin
        e_wb = wb; e_m2r = rd | po;
        if (wr) begin mm[a] = sd; known[a] = 1; end
        if (rd) begin e_data = mm[a]; dk = known[a]; end
        if (pu) begin
          mm[e_sp] = sd; known[e_sp] = 1;
          if (e_sp == 0) e_ovf = 1;
          e_sp = (e_sp + 2047) % 2048;
        end
        if (po) begin
          if (e_sp == 2047) e_udf = 1;
          e_sp = (e_sp + 1) % 2048;
          e_data = mm[e_sp]; dk = known[e_sp];
        end
      end
    end else if (dbg_we) begin
      mm[dbg_addr] = dbg_wdata; known[dbg_addr] = 1;
    end
    check("wb_en", 32'(wb_en_out), 32'(e_wb));
    check("mem_to_reg", 32'(mem_to_reg_out), 32'(e_m2r));
    check("dest", 32'(dest_reg_out), 32'(e_dest));
    check("alu", 32'(alu_result_out), 32'(e_alu));
    check("sp", 32'(sp_out), 32'(e_sp));
    check("ovf", 32'(stack_ovf), 32'(e_ovf));
    check("udf", 32'(stack_udf), 32'(e_udf));
    check("op_err", 32'(op_err), 32'(e_err));
    if (dk) check("data", 32'(mem_data_out), 32'(e_data));
  endtask

  task automatic preload(input logic [10:0] a, input logic [15:0] d);
    idle();
    stall = 1; dbg_we = 1; dbg_addr = a; dbg_wdata = d;
    step();
  endtask

  initial begin
    logic [3:0] v;
    int r;
    idle();
    reset = 1; step(); step();
    check("t1_sp", 32'(sp_out), 32'h7FF);
    check("t1_flags", 32'({stack_ovf, stack_udf, op_err, wb_en_out, mem_to_reg_out}), 32'h0);
    // store then load same address on the next cycle
    op(0, 1, 0, 0, 16'h0010, 16'hBEEF); step();
    op(1, 0, 0, 0, 16'h0010, 16'h0); step();
    check("t2_data", 32'(mem_data_out), 32'hBEEF);
    check("t2_m2r", 32'(mem_to_reg_out), 32'h1);
    // upper address bits ignored
    op(1, 0, 0, 0, 16'hF810, 16'h0); step();
    check("t2_alias", 32'(mem_data_out), 32'hBEEF);
    // dbg_we ignored while not stalled
    idle(); dbg_we = 1; dbg_addr = 11'h010; dbg_wdata = 16'hDEAD; step();
    op(1, 0, 0, 0, 16'h0010, 16'h0); step();
    check("dbg_ignored", 32'(mem_data_out), 32'hBEEF);
    // push/pop pair
    op(0, 0, 1, 0, 16'h0, 16'h1111); step();
    op(0, 0, 1, 0, 16'h0, 16'h2222); step();
    check("t3_sp_push", 32'(sp_out), 32'h7FD);
    op(0, 0, 0, 1, 16'h0, 16'h0); step();
    check("t3_pop1", 32'(mem_data_out), 32'h2222);
    op(0, 0, 0, 1, 16'h0, 16'h0); step();
    check("t3_pop2", 32'(mem_data_out), 32'h1111);
    check("t3_sp", 32'(sp_out), 32'h7FF);
    // pop underflow reads mem[0]
    preload(11'h000, 16'hCAFE);
    op(0, 0, 0, 1, 16'h0, 16'h0); step();
    check("t4_sp", 32'(sp_out), 32'h000);
    check("t4_udf", 32'(stack_udf), 32'h1);
    check("t4_data", 32'(mem_data_out), 32'hCAFE);
    // stall freezes, flush squashes
    preload(11'h020, 16'h0BAD);
    op(0, 1, 0, 0, 16'h0020, 16'h5555); stall = 1;
    repeat (3) step();
    op(0, 1, 0, 0, 16'h0020, 16'h6666); flush = 1; stall = 1; wb = 1; step();
    check("t5_flush_wb", 32'(wb_en_out), 32'h0);
    op(1, 0, 0, 0, 16'h0020, 16'h0); step();
    check("t5_mem", 32'(mem_data_out), 32'h0BAD);
    // conflicting op bits
    op(0, 1, 1, 0, 16'h0020, 16'h7777); wb = 1; step();
    check("t6_err", 32'(op_err), 32'h1);
    check("t6_sp", 32'(sp_out), 32'h000);
    check("t6_wb", 32'(wb_en_out), 32'h0);
    op(1, 0, 0, 0, 16'h0020, 16'h0); step();
    check("t6_mem20", 32'(mem_data_out), 32'h0BAD);
    op(1, 0, 0, 0, 16'h0000, 16'h0); step();
    check("t6_mem0", 32'(mem_data_out), 32'hCAFE);
    // push overflow at SP=0
    op(0, 0, 1, 0, 16'h0, 16'h4444); step();
    check("ovf_sp", 32'(sp_out), 32'h7FF);
    check("ovf_flag", 32'(stack_ovf), 32'h1);
    op(1, 0, 0, 0, 16'h0000, 16'h0); step();
    check("ovf_mem", 32'(mem_data_out), 32'h4444);
    // reset drops a concurrent store
    preload(11'h030, 16'h1234);
    op(0, 1, 0, 0, 16'h0030, 16'h5678); reset = 1; step();
    op(1, 0, 0, 0, 16'h0030, 16'h0); step();
    check("rst_drop", 32'(mem_data_out), 32'h1234);
    // random traffic
    for (int i = 0; i < 500; i++) begin
      r = int'($urandom_range(0, 99));
      op(0, 0, 0, 0, 16'($urandom_range(0, 31)) | (16'($urandom) & 16'hF800), 16'($urandom));
      case ($urandom_range(0, 5))
        1: rd = 1;
        2: wr = 1;
        3: pu = 1;
        4: po = 1;
        5: begin
          do v = 4'($urandom); while ($countones(v) < 2);
          {rd, wr, pu, po} = v;
        end
        default: ;
      endcase
      stall = r < 12;
      flush = r >= 12 && r < 20;
      reset = r == 99;
      dbg_we = 1'($urandom);
      dbg_addr = 11'($urandom_range(0, 31));
      dbg_wdata = 16'($urandom);
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
